// File: rtl/spi_controller.sv
// spi_controller: byte-wide SPI master behind the SPI card window.
// 68030 register interface (020-style, 8-bit port) terminated with DSACK_N,
// SPI mode 0 serialiser running on CLKCPU.
// Optional build macro: SPI_WAIT_EN -- a DATA write while a transfer is in
// progress stalls the bus cycle until the shifter is idle instead of being
// dropped with OVERRUN.
module spi_controller #(
    parameter int CLKDIV = 4,
    parameter int NCS    = 2
) (
    input  logic           CLKCPU,
    input  logic           RESET,
    input  logic           SEL_N,
    input  logic           AS20,
    input  logic           DS20,
    input  logic           RW20,
    input  logic [1:0]     A,
    input  logic [7:0]     D,
    output logic [7:0]     DOUT,
    output logic           DOE,
    output logic           DSACK_N,
    output logic           SCLK,
    output logic           MOSI,
    input  logic           MISO,
    output logic [NCS-1:0] CS_N
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [7:0] DIV_RELOAD = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_ACK  = 2'd1,
        B_END  = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } spi_state_t;

    // Synchronisers for the asynchronous CPU strobes
    logic as_meta_r;
    logic as_sync_r;
    logic ds_meta_r;
    logic ds_sync_r;

    // Bus side
    bus_state_t bus_state_r;
    bus_state_t bus_next_s;
    logic       cycle_start_s;
    logic       data_wr_s;
    logic       hold_s;
    logic       access_s;
    logic       start_s;
    logic       overrun_set_s;
    logic       status_rd_s;
    logic [7:0] read_mux_s;

    // Registers
    logic [NCS-1:0] cs_n_r;
    logic           overrun_r;
    logic [7:0]     dout_r;
    logic           doe_r;
    logic           dsack_n_r;

    // SPI side
    spi_state_t spi_state_r;
    spi_state_t spi_next_s;
    logic       busy_s;
    logic       div_zero_s;
    logic [7:0] div_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] tx_r;
    logic [7:0] rx_shift_r;
    logic [7:0] rx_r;
    logic       sclk_r;
    logic       mosi_r;

    assign busy_s        = (spi_state_r != S_IDLE);
    assign div_zero_s    = (div_r == 8'd0);
    assign cycle_start_s = (ds_sync_r == 1'b0) && (SEL_N == 1'b0);
    assign data_wr_s     = (RW20 == 1'b0) && (A == REG_DATA);

`ifdef SPI_WAIT_EN
    // A DATA write that finds the shifter busy waits in B_IDLE; no OVERRUN.
    assign hold_s        = data_wr_s && busy_s;
    assign overrun_set_s = 1'b0;
`else
    // A DATA write that finds the shifter busy is acknowledged but dropped.
    assign hold_s        = 1'b0;
    assign overrun_set_s = access_s && data_wr_s && busy_s;
`endif

    assign start_s     = access_s && data_wr_s && !busy_s;
    assign status_rd_s = access_s && (RW20 == 1'b1) && (A == REG_STATUS);

    // Two-flop synchronisers on AS20/DS20 (idle high)
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            as_meta_r <= 1'b1;
            as_sync_r <= 1'b1;
            ds_meta_r <= 1'b1;
            ds_sync_r <= 1'b1;
        end else begin
            as_meta_r <= AS20;
            as_sync_r <= as_meta_r;
            ds_meta_r <= DS20;
            ds_sync_r <= ds_meta_r;
        end
    end

    // Bus FSM state register
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            bus_state_r <= B_IDLE;
        end else begin
            bus_state_r <= bus_next_s;
        end
    end

    // Bus FSM next state; the register access fires on the IDLE->ACK step
    always_comb begin
        bus_next_s = bus_state_r;
        access_s   = 1'b0;
        case (bus_state_r)
            B_IDLE: begin
                if (cycle_start_s && !hold_s) begin
                    bus_next_s = B_ACK;
                    access_s   = 1'b1;
                end else begin
                    bus_next_s = B_IDLE;
                end
            end
            B_ACK: begin
                if (as_sync_r) begin
                    bus_next_s = B_END;
                end else begin
                    bus_next_s = B_ACK;
                end
            end
            B_END: begin
                bus_next_s = B_IDLE;
            end
            default: begin
                bus_next_s = B_IDLE;
            end
        endcase
    end

    // Read data selection from pre-edge register values
    always_comb begin
        read_mux_s = 8'hFF;
        case (A)
            REG_DATA:   read_mux_s = rx_r;
            REG_STATUS: read_mux_s = {6'b000000, overrun_r, busy_s};
            REG_CTRL:   read_mux_s = {{(8 - NCS){1'b0}}, ~cs_n_r};
            default:    read_mux_s = 8'hFF;
        endcase
    end

    // Register file, bus outputs and OVERRUN flag (set beats clear)
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            cs_n_r    <= {NCS{1'b1}};
            overrun_r <= 1'b0;
            dout_r    <= 8'hFF;
            doe_r     <= 1'b0;
            dsack_n_r <= 1'b1;
        end else begin
            dsack_n_r <= (bus_next_s != B_ACK);
            if (access_s) begin
                doe_r <= RW20;
                if (RW20) begin
                    dout_r <= read_mux_s;
                end
            end else if (bus_next_s != B_ACK) begin
                doe_r <= 1'b0;
            end
            if (access_s && (RW20 == 1'b0) && (A == REG_CTRL)) begin
                cs_n_r <= ~D[NCS-1:0];
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (status_rd_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // SPI FSM state register
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            spi_state_r <= S_IDLE;
        end else begin
            spi_state_r <= spi_next_s;
        end
    end

    // SPI FSM next state: each SCLK phase lasts CLKDIV cycles
    always_comb begin
        spi_next_s = spi_state_r;
        case (spi_state_r)
            S_IDLE: begin
                if (start_s) begin
                    spi_next_s = S_LOW;
                end else begin
                    spi_next_s = S_IDLE;
                end
            end
            S_LOW: begin
                if (div_zero_s) begin
                    spi_next_s = S_HIGH;
                end else begin
                    spi_next_s = S_LOW;
                end
            end
            S_HIGH: begin
                if (div_zero_s) begin
                    if (bit_cnt_r == 3'd0) begin
                        spi_next_s = S_IDLE;
                    end else begin
                        spi_next_s = S_LOW;
                    end
                end else begin
                    spi_next_s = S_HIGH;
                end
            end
            default: begin
                spi_next_s = S_IDLE;
            end
        endcase
    end

    // SPI datapath: divider, bit counter, shifters, SCLK/MOSI; RX commits only at the end
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            div_r      <= 8'd0;
            bit_cnt_r  <= 3'd0;
            tx_r       <= 8'hFF;
            rx_shift_r <= 8'hFF;
            rx_r       <= 8'hFF;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b1;
        end else begin
            case (spi_state_r)
                S_IDLE: begin
                    if (start_s) begin
                        tx_r      <= D;
                        mosi_r    <= D[7];
                        bit_cnt_r <= 3'd7;
                        div_r     <= DIV_RELOAD;
                        sclk_r    <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (div_zero_s) begin
                        sclk_r     <= 1'b1;
                        rx_shift_r <= {rx_shift_r[6:0], MISO};
                        div_r      <= DIV_RELOAD;
                    end else begin
                        div_r <= div_r - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_zero_s) begin
                        sclk_r <= 1'b0;
                        div_r  <= DIV_RELOAD;
                        if (bit_cnt_r == 3'd0) begin
                            rx_r <= rx_shift_r;
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            tx_r      <= {tx_r[6:0], 1'b0};
                            mosi_r    <= tx_r[6];
                        end
                    end else begin
                        div_r <= div_r - 8'd1;
                    end
                end
                default: begin
                    sclk_r <= 1'b0;
                end
            endcase
        end
    end

    assign DOUT    = dout_r;
    assign DOE     = doe_r;
    assign DSACK_N = dsack_n_r;
    assign SCLK    = sclk_r;
    assign MOSI    = mosi_r;
    assign CS_N    = cs_n_r;

endmodule
